// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: clear/stall control, packed read ports,
// two byte-strobed write ports and the status outputs.
// With RF_PARITY_EN defined the bundle also carries par_err.
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                       clr_req;
  logic                       stall;
  logic                       ready;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic                       wr0_en;
  logic                       wr1_en;
  logic [ADDR_W-1:0]          wr0_addr;
  logic [ADDR_W-1:0]          wr1_addr;
  logic [DATA_W-1:0]          wr0_data;
  logic [DATA_W-1:0]          wr1_data;
  logic [DATA_W/8-1:0]        wr0_be;
  logic [DATA_W/8-1:0]        wr1_be;
  logic                       wr_conflict;
`ifdef RF_PARITY_EN
  logic [NUM_RD-1:0]          par_err;

  modport master (
    output clr_req, stall, rd_addr,
    output wr0_en, wr0_addr, wr0_data, wr0_be,
    output wr1_en, wr1_addr, wr1_data, wr1_be,
    input  ready, rd_data, wr_conflict, par_err
  );

  modport slave (
    input  clr_req, stall, rd_addr,
    input  wr0_en, wr0_addr, wr0_data, wr0_be,
    input  wr1_en, wr1_addr, wr1_data, wr1_be,
    output ready, rd_data, wr_conflict, par_err
  );
`else
  modport master (
    output clr_req, stall, rd_addr,
    output wr0_en, wr0_addr, wr0_data, wr0_be,
    output wr1_en, wr1_addr, wr1_data, wr1_be,
    input  ready, rd_data, wr_conflict
  );

  modport slave (
    input  clr_req, stall, rd_addr,
    input  wr0_en, wr0_addr, wr0_data, wr0_be,
    input  wr1_en, wr1_addr, wr1_data, wr1_be,
    output ready, rd_data, wr_conflict
  );
`endif
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port integer register file: NUM_RD combinational read ports with
// per-byte write-through bypass, two byte-strobed write ports (port 1 wins
// on overlapping lanes), optional hardwired-zero entry 0, and an INIT/CLEAR
// sweep that zeroes one entry per cycle before raising ready.
// Optional feature macro: RF_PARITY_EN (per-byte even parity + par_err).
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_CLEAR} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   w_ptr_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]   w_ra [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] w_rd_data;
  logic                w_run;
  logic                w_wr0_ok;
  logic                w_wr1_ok;
`ifdef RF_PARITY_EN
  logic [NB-1:0]       r_par [DEPTH];
  logic [NUM_RD-1:0]   w_par_err;
`endif

  // Writes (and bypass) only take effect in RUN without stall; a write to the
  // hardwired zero entry is dropped entirely, including from conflict detection.
  assign w_run    = (r_state == S_RUN);
  assign w_wr0_ok = w_run && !bus.stall && bus.wr0_en &&
                    !((ZERO_REG != 0) && (bus.wr0_addr == '0));
  assign w_wr1_ok = w_run && !bus.stall && bus.wr1_en &&
                    !((ZERO_REG != 0) && (bus.wr1_addr == '0));

  // State register: sweep pointer and mode, asynchronously returned to INIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next state: sweeps run exactly DEPTH cycles; clr_req only honoured in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_INIT, S_CLEAR: begin
        w_ptr_nxt = r_ptr + ADDR_W'(1);
        if (r_ptr == PTR_LAST) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (bus.clr_req) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // Status outputs: ready mirrors RUN; conflict needs overlapping lanes on one entry.
  always_comb begin
    bus.ready       = w_run;
    bus.wr_conflict = w_wr0_ok && w_wr1_ok && (bus.wr0_addr == bus.wr1_addr) &&
                      (|(bus.wr0_be & bus.wr1_be));
  end

  // Array update: sweep clears entry[ptr]; otherwise byte-lane writes, port 1 last so it wins.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_ptr] <= '0;
`ifdef RF_PARITY_EN
      r_par[r_ptr] <= '0;
`endif
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (w_wr0_ok && bus.wr0_be[k]) begin
          r_mem[bus.wr0_addr][k*8 +: 8] <= bus.wr0_data[k*8 +: 8];
`ifdef RF_PARITY_EN
          r_par[bus.wr0_addr][k] <= ^bus.wr0_data[k*8 +: 8];
`endif
        end
      end
      for (int k = 0; k < NB; k++) begin
        if (w_wr1_ok && bus.wr1_be[k]) begin
          r_mem[bus.wr1_addr][k*8 +: 8] <= bus.wr1_data[k*8 +: 8];
`ifdef RF_PARITY_EN
          r_par[bus.wr1_addr][k] <= ^bus.wr1_data[k*8 +: 8];
`endif
        end
      end
    end
  end

  // Unpack the read addresses.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) w_ra[i] = bus.rd_addr[i*ADDR_W +: ADDR_W];
  end

  // Read path: per-byte bypass (port 1 over port 0), else array; zero outside RUN or for entry 0.
  always_comb begin
    w_rd_data = '0;
`ifdef RF_PARITY_EN
    w_par_err = '0;
`endif
    for (int i = 0; i < NUM_RD; i++) begin
      if (w_run && !((ZERO_REG != 0) && (w_ra[i] == '0))) begin
        for (int k = 0; k < NB; k++) begin
          if (w_wr1_ok && bus.wr1_be[k] && (bus.wr1_addr == w_ra[i])) begin
            w_rd_data[i*DATA_W + k*8 +: 8] = bus.wr1_data[k*8 +: 8];
          end else if (w_wr0_ok && bus.wr0_be[k] && (bus.wr0_addr == w_ra[i])) begin
            w_rd_data[i*DATA_W + k*8 +: 8] = bus.wr0_data[k*8 +: 8];
          end else begin
            w_rd_data[i*DATA_W + k*8 +: 8] = r_mem[w_ra[i]][k*8 +: 8];
`ifdef RF_PARITY_EN
            if ((^r_mem[w_ra[i]][k*8 +: 8]) != r_par[w_ra[i]][k]) w_par_err[i] = 1'b1;
`endif
          end
        end
      end
    end
  end

  assign bus.rd_data = w_rd_data;
`ifdef RF_PARITY_EN
  assign bus.par_err = w_par_err;
`endif

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port integer register file, the next-generation replacement for the single-write CPU register file in the pipeline decode/writeback stages.
- Configurable read-port count; two byte-strobed write ports (writeback + load/CSR return).
- Per-byte write-through bypass.
- Hardware init/clear sweep state machine with a ready handshake.
- Depth maps to an SRAM-like array cleared one entry per cycle.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8.
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
NUM_RD, 2, number of read ports (1..4).
ZERO_REG, 1, 1 = entry 0 hardwired to zero; 0 = entry 0 is an ordinary register.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  reset: asynchronous assert, active-low; a low level resets all state.
clr_req  in  1  request full-array clear; level-sampled in RUN.
stall  in  1  pipeline hold: suppress writes and bypass.
ready  out  1  array initialised, reads valid.
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
rd_data  out  NUM_RD*DATA_W  packed read data, combinational from rd_addr.
wr0_en, wr1_en  in  1  write enables.
wr0_addr, wr1_addr  in  ADDR_W  write addresses.
wr0_data, wr1_data  in  DATA_W  write data.
wr0_be, wr1_be  in  DATA_W/8  byte strobes; bit k covers byte k.
wr_conflict  out  1  both ports hit the same writable entry with overlapping strobes this cycle.

Behaviour:
- States: INIT, RUN, CLEAR; sweep pointer ptr (ADDR_W bits).
- Reset (rst low, asynchronous):
  - state=INIT, ptr=0, ready=0.
  - Array contents are not reset directly.
- INIT and CLEAR:
  - Each cycle entry[ptr] <= 0, then ptr++.
  - When ptr == DEPTH-1 is written, next state=RUN and ready=1 from the following cycle.
  - Sweep length is exactly DEPTH cycles.
  - All writes are dropped; rd_data=0 on every port; wr_conflict=0.
- RUN:
  - clr_req=1 sampled -> state CLEAR, ptr=0, ready=0 next cycle.
  - clr_req is ignored outside RUN; a sweep in progress continues unchanged.
- Write, RUN and stall=0:
  - For each port with en=1, each byte k with be[k]=1 is updated at the edge.
  - Bytes with be[k]=0 are untouched.
- Same entry, both ports:
  - Bytes merge per lane.
  - On overlapping lanes, port 1 wins.
  - wr_conflict=1 combinationally that cycle.
- ZERO_REG=1 and addr==0:
  - Write is dropped and excluded from conflict detection.
  - Reads of entry 0 return 0 with no bypass.
- Read:
  - Zero-latency combinational read.
  - Bypass per byte: if a write targets rd_addr this cycle, in RUN with stall=0, the byte shows the new data.
  - Bypass uses the same port-1-over-port-0 priority as the write; otherwise the byte shows array contents.
- stall=1:
  - No array update.
  - Reads return array contents only (no bypass).
  - wr_conflict=0.
- rst asserted mid-sweep or mid-write: immediate return to INIT; the sweep restarts at ptr=0.

Optional Feature:
RF_PARITY_EN:
- Defined:
  - Each entry stores one even-parity bit per byte, generated on write and on sweep (parity of 0 = 0).
  - Adds output par_err [NUM_RD-1:0].
  - par_err[i]=1 when any array-sourced byte on port i fails its parity check; bypassed bytes are never flagged.
  - par_err is forced to 0 outside RUN and for the zero register.
- Undefined: no parity storage and no par_err port.

Test Plan:
1. Release rst, DEPTH=32 -> ready=0 for 32 cycles, ready=1 at cycle 33; rd_data=0 throughout; a wr0 to addr 3 issued at cycle 10 is lost (read of 3 after ready returns 0).
2. RUN, wr0 addr 5 data 0xDEADBEEF be 0xF, read addr 5 same cycle -> rd_data=0xDEADBEEF (bypass); next cycle same value from array.
3. Entry 7 holds 0x11223344; wr0 addr 7 data 0xAAAAAAAA be 0x3 and wr1 addr 7 data 0xBBBBBBBB be 0x6 -> wr_conflict=1, entry 7 = 0x11BBBBAA.
4. ZERO_REG=1, wr1 addr 0 data 0xFFFFFFFF be 0xF, read port 0 addr 0 -> rd_data 0 both same cycle and after; wr_conflict=0.
5. stall=1 with wr0 addr 9 data 0x12345678 -> read addr 9 returns old value 0; after stall drops with no write, still 0.
6. Pulse clr_req in RUN with several nonzero entries; assert rst low 5 cycles into the sweep -> ready=0, ptr restarts; after 32 further cycles all entries read 0 and ready=1.
